// File: rtl/result_bus_arbiter.sv
// Round-robin arbiter that funnels functional-unit results onto a single common result bus.
// One registered broadcast slot; a new winner may replace a broadcast in the same cycle it is consumed.
module result_bus_arbiter #(
    parameter int NUMBER_FUNCTIONAL_UNITS = 4,
    parameter int TAG_WIDTH               = 5,
    parameter int DATA_WIDTH              = 32
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [NUMBER_FUNCTIONAL_UNITS-1:0]            fu_valid,
    input  logic [NUMBER_FUNCTIONAL_UNITS*TAG_WIDTH-1:0]  fu_tag,
    input  logic [NUMBER_FUNCTIONAL_UNITS*DATA_WIDTH-1:0] fu_data,
    output logic [NUMBER_FUNCTIONAL_UNITS-1:0]            fu_ready,
    output logic                                          cdb_valid,
    output logic [TAG_WIDTH-1:0]                          cdb_tag,
    output logic [DATA_WIDTH-1:0]                         cdb_data,
    output logic [$clog2(NUMBER_FUNCTIONAL_UNITS)-1:0]    cdb_source,
    input  logic                                          cdb_ready
);

    localparam int                 SRC_W      = $clog2(NUMBER_FUNCTIONAL_UNITS);
    localparam logic [SRC_W:0]     UNIT_COUNT = (SRC_W+1)'(NUMBER_FUNCTIONAL_UNITS);
    localparam logic [SRC_W-1:0]   LAST_UNIT  = SRC_W'(NUMBER_FUNCTIONAL_UNITS - 1);

    logic [SRC_W-1:0]      rr_pointer;
    logic [SRC_W-1:0]      grant_index;
    logic [SRC_W-1:0]      next_pointer;
    logic [SRC_W:0]        probe_sum;
    logic [SRC_W:0]        probe_index;
    logic                  grant_found;
    logic                  slot_free;
    logic                  transfer;
    logic [TAG_WIDTH-1:0]  winner_tag;
    logic [DATA_WIDTH-1:0] winner_data;

    // Probe units starting at rr_pointer, wrapping past the last unit; the first requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_index = '0;
        probe_sum   = '0;
        probe_index = '0;
        for (int k = 0; k < NUMBER_FUNCTIONAL_UNITS; k++) begin
            probe_sum   = {1'b0, rr_pointer} + (SRC_W+1)'(k);
            probe_index = (probe_sum >= UNIT_COUNT) ? probe_sum - UNIT_COUNT : probe_sum;
            if (!grant_found && fu_valid[probe_index[SRC_W-1:0]]) begin
                grant_found = 1'b1;
                grant_index = probe_index[SRC_W-1:0];
            end
        end
    end

    assign slot_free    = !cdb_valid || cdb_ready;
    assign next_pointer = (grant_index == LAST_UNIT) ? '0 : grant_index + 1'b1;
    assign transfer     = |fu_ready;

    always_comb begin
        fu_ready = '0;
        if (!reset && slot_free && grant_found) begin
            fu_ready[grant_index] = 1'b1;
        end
    end

    always_comb begin
        winner_tag  = '0;
        winner_data = '0;
        for (int i = 0; i < NUMBER_FUNCTIONAL_UNITS; i++) begin
            if (grant_index == SRC_W'(i)) begin
                winner_tag  = fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
                winner_data = fu_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Payload only changes on a transfer, so it stays frozen both while stalled and while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cdb_valid  <= 1'b0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_source <= '0;
            rr_pointer <= '0;
        end else if (transfer) begin
            cdb_valid  <= 1'b1;
            cdb_tag    <= winner_tag;
            cdb_data   <= winner_data;
            cdb_source <= grant_index;
            rr_pointer <= next_pointer;
        end else if (cdb_ready) begin
            cdb_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Self-checking bench for result_bus_arbiter: directed scenarios then randomized traffic,
// all compared against a cycle-level behavioural model of the broadcast slot and round-robin order.
module tb_result_bus_arbiter;

    localparam int N  = 4;
    localparam int TW = 5;
    localparam int DW = 32;
    localparam int SW = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    fu_valid;
    logic [N*TW-1:0] fu_tag;
    logic [N*DW-1:0] fu_data;
    logic [N-1:0]    fu_ready;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic [SW-1:0]   cdb_source;
    logic            cdb_ready;

    int check_count = 0;
    int pass_count  = 0;

    int            m_ptr   = 0;
    logic          m_valid = 1'b0;
    logic [TW-1:0] m_tag   = '0;
    logic [DW-1:0] m_data  = '0;
    int            m_src   = 0;

    logic [N-1:0]  sampled_ready;
    logic [TW-1:0] saved_tag;
    logic [DW-1:0] saved_data;

    always #5 clock = ~clock;

    result_bus_arbiter #(
        .NUMBER_FUNCTIONAL_UNITS(N),
        .TAG_WIDTH(TW),
        .DATA_WIDTH(DW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fu_valid(fu_valid),
        .fu_tag(fu_tag),
        .fu_data(fu_data),
        .fu_ready(fu_ready),
        .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag),
        .cdb_data(cdb_data),
        .cdb_source(cdb_source),
        .cdb_ready(cdb_ready)
    );

    // Winner this cycle according to the rules: none if in reset or the slot is blocked.
    function automatic int expectedWinner();
        if (reset) return -1;
        if (m_valid && !cdb_ready) return -1;
        for (int k = 0; k < N; k++) begin
            if (fu_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic rdy, input logic rst);
        fu_valid  = v;
        cdb_ready = rdy;
        reset     = rst;
        for (int i = 0; i < N; i++) begin
            fu_tag[i*TW +: TW]  = TW'($urandom);
            fu_data[i*DW +: DW] = $urandom;
        end
    endtask

    task automatic runCycle();
        int            w;
        logic [N-1:0]  exp_ready;
        logic [TW-1:0] w_tag;
        logic [DW-1:0] w_data;
        logic          rdy;
        logic          rst;
        @(negedge clock);
        w         = expectedWinner();
        exp_ready = '0;
        w_tag     = '0;
        w_data    = '0;
        if (w >= 0) begin
            exp_ready[w] = 1'b1;
            w_tag        = fu_tag[w*TW +: TW];
            w_data       = fu_data[w*DW +: DW];
        end
        rdy           = cdb_ready;
        rst           = reset;
        sampled_ready = fu_ready;
        checkOutput("fu_ready", 64'(fu_ready), 64'(exp_ready));
        @(posedge clock);
        #1;
        if (rst) begin
            m_valid = 1'b0;
            m_tag   = '0;
            m_data  = '0;
            m_src   = 0;
            m_ptr   = 0;
        end else if (w >= 0) begin
            m_valid = 1'b1;
            m_tag   = w_tag;
            m_data  = w_data;
            m_src   = w;
            m_ptr   = (w + 1) % N;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        checkOutput("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        checkOutput("cdb_tag", 64'(cdb_tag), 64'(m_tag));
        checkOutput("cdb_data", 64'(cdb_data), 64'(m_data));
        checkOutput("cdb_source", 64'(cdb_source), 64'(m_src));
    endtask

    task automatic resetCycle();
        applyStimulus('1, 1'b1, 1'b1);
        runCycle();
    endtask

    initial begin
        $display("[TB] starting result_bus_arbiter bench");
        applyStimulus('0, 1'b1, 1'b1);
        runCycle();
        runCycle();
        checkOutput("reset_valid", 64'(cdb_valid), 64'd0);
        checkOutput("reset_source", 64'(cdb_source), 64'd0);

        // Single request with a known payload, then confirm the pointer moved to unit 3.
        applyStimulus(4'b0100, 1'b1, 1'b0);
        fu_tag[2*TW +: TW]  = 5'h0A;
        fu_data[2*DW +: DW] = 32'hDEAD_BEEF;
        runCycle();
        checkOutput("single_ready", 64'(sampled_ready), 64'b0100);
        checkOutput("single_valid", 64'(cdb_valid), 64'd1);
        checkOutput("single_tag", 64'(cdb_tag), 64'h0A);
        checkOutput("single_data", 64'(cdb_data), 64'hDEAD_BEEF);
        checkOutput("single_source", 64'(cdb_source), 64'd2);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        runCycle();
        checkOutput("single_next_source", 64'(cdb_source), 64'd3);

        // Full contention from reset rotates 0,1,2,3 twice.
        resetCycle();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 1'b1, 1'b0);
            runCycle();
            checkOutput("contention_source", 64'(cdb_source), 64'(k % 4));
            checkOutput("contention_valid", 64'(cdb_valid), 64'd1);
        end

        // Backpressure: unit 1 broadcast, three stalled cycles, then unit 3 is next.
        resetCycle();
        applyStimulus(4'b0010, 1'b1, 1'b0);
        runCycle();
        checkOutput("bp_first_source", 64'(cdb_source), 64'd1);
        saved_tag  = cdb_tag;
        saved_data = cdb_data;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1011, 1'b0, 1'b0);
            runCycle();
            checkOutput("bp_stall_ready", 64'(sampled_ready), 64'd0);
            checkOutput("bp_stall_valid", 64'(cdb_valid), 64'd1);
            checkOutput("bp_stall_tag", 64'(cdb_tag), 64'(saved_tag));
            checkOutput("bp_stall_data", 64'(cdb_data), 64'(saved_data));
            checkOutput("bp_stall_source", 64'(cdb_source), 64'd1);
        end
        applyStimulus(4'b1011, 1'b1, 1'b0);
        runCycle();
        checkOutput("bp_release_ready", 64'(sampled_ready), 64'b1000);
        checkOutput("bp_release_source", 64'(cdb_source), 64'd3);

        // Wrap from pointer 3 back to unit 0, then unit 1.
        resetCycle();
        applyStimulus(4'b0100, 1'b1, 1'b0);
        runCycle();
        applyStimulus(4'b0011, 1'b1, 1'b0);
        runCycle();
        checkOutput("wrap_first", 64'(cdb_source), 64'd0);
        applyStimulus(4'b0011, 1'b1, 1'b0);
        runCycle();
        checkOutput("wrap_second", 64'(cdb_source), 64'd1);

        // Reset while a broadcast is stalled discards it and restarts at unit 0.
        resetCycle();
        applyStimulus(4'b0100, 1'b1, 1'b0);
        runCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0);
        runCycle();
        checkOutput("midreset_stalled", 64'(cdb_valid), 64'd1);
        applyStimulus(4'b1111, 1'b0, 1'b1);
        runCycle();
        checkOutput("midreset_ready", 64'(sampled_ready), 64'd0);
        checkOutput("midreset_valid", 64'(cdb_valid), 64'd0);
        checkOutput("midreset_tag", 64'(cdb_tag), 64'd0);
        checkOutput("midreset_data", 64'(cdb_data), 64'd0);
        checkOutput("midreset_source", 64'(cdb_source), 64'd0);
        applyStimulus(4'b1111, 1'b1, 1'b0);
        runCycle();
        checkOutput("midreset_first_grant", 64'(sampled_ready), 64'b0001);

        // Idle drain: one broadcast visible for exactly one cycle, payload retained.
        resetCycle();
        applyStimulus(4'b0001, 1'b1, 1'b0);
        runCycle();
        checkOutput("drain_valid_on", 64'(cdb_valid), 64'd1);
        saved_tag  = cdb_tag;
        saved_data = cdb_data;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            runCycle();
            checkOutput("drain_valid_off", 64'(cdb_valid), 64'd0);
            checkOutput("drain_tag_held", 64'(cdb_tag), 64'(saved_tag));
            checkOutput("drain_data_held", 64'(cdb_data), 64'(saved_data));
        end

        // Randomized traffic with occasional backpressure and reset.
        resetCycle();
        for (int k = 0; k < 400; k++) begin
            applyStimulus(N'($urandom), ($urandom_range(3) != 0), ($urandom_range(49) == 0));
            runCycle();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
